// File: rtl/lib_cpu.sv
// Shared CPU decode types: opcode and funct classes as produced by the instruction decoder.
package lib_cpu;

   typedef enum logic [2:0] {
      LW,
      SW,
      RTYPE,
      BEQ,
      ADDI,
      J,
      INVALID_OP
   } OPECODE;

   typedef enum logic [2:0] {
      ADD,
      SUB,
      AND,
      OR,
      SLT,
      INVALID_FU
   } FUNCT;

endpackage

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: Moore FSM driving datapath selects and write strobes.
// Optional feature ILLEGAL_TRAP_EN: illegal opcode/funct halts the controller until reset.
module mc_controller (
   input  logic            clk,
   input  logic            reset_n,
   input  lib_cpu::OPECODE op,
   input  lib_cpu::FUNCT   funct,
   input  logic            zero,
   output logic            pc_en,
   output logic            ir_write,
   output logic            mem_write,
   output logic            reg_write,
   output logic            iord,
   output logic            mem_to_reg,
   output logic            reg_dst,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      pc_src,
   output logic [2:0]      alu_control,
   output logic            halted
);

   import lib_cpu::*;

   typedef enum logic [3:0] {
      StRst,
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExec,
      StAluWb,
      StBranch,
      StAddiEx,
      StAddiWb,
      StJump,
      StHalt
   } state_e;

   state_e state_q, state_d;
   logic   pc_write;
   logic   branch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRst;
      end else begin
         state_q <= state_d;
      end
   end

   // op/funct only influence the transition out of DECODE, MEMADR and EXEC.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRst:    state_d = StFetch;
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (op)
               LW, SW: state_d = StMemAdr;
               RTYPE:  state_d = StExec;
               BEQ:    state_d = StBranch;
               ADDI:   state_d = StAddiEx;
               J:      state_d = StJump;
`ifdef ILLEGAL_TRAP_EN
               default: state_d = StHalt;
`else
               default: state_d = StFetch;
`endif
            endcase
         end
         StMemAdr: state_d = (op == SW) ? StMemWr : StMemRd;
         StMemRd:  state_d = StMemWb;
         StMemWb:  state_d = StFetch;
         StMemWr:  state_d = StFetch;
         StExec: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = (funct == ADD || funct == SUB || funct == AND || funct == OR ||
                       funct == SLT) ? StAluWb : StHalt;
`else
            state_d = StAluWb;
`endif
         end
         StAluWb:  state_d = StFetch;
         StBranch: state_d = StFetch;
         StAddiEx: state_d = StAddiWb;
         StAddiWb: state_d = StFetch;
         StJump:   state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StRst;
      endcase
   end

   always_comb begin
      pc_write    = 1'b0;
      branch      = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      iord        = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_src      = 2'b00;
      alu_control = 3'b000;
      halted      = 1'b0;
      case (state_q)
         StFetch: begin
            alu_src_b   = 2'b01;
            alu_control = 3'b010;
            ir_write    = 1'b1;
            pc_write    = 1'b1;
         end
         StDecode: begin
            alu_src_b   = 2'b11;
            alu_control = 3'b010;
         end
         StMemAdr, StAddiEx: begin
            alu_src_a   = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = 3'b010;
         end
         StMemRd: iord = 1'b1;
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StMemWr: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         StExec: begin
            alu_src_a = 1'b1;
            case (funct)
               ADD:     alu_control = 3'b010;
               SUB:     alu_control = 3'b110;
               AND:     alu_control = 3'b000;
               OR:      alu_control = 3'b001;
               SLT:     alu_control = 3'b111;
               default: alu_control = 3'b010;
            endcase
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StBranch: begin
            alu_src_a   = 1'b1;
            alu_control = 3'b110;
            pc_src      = 2'b01;
            branch      = 1'b1;
         end
         StAddiWb: reg_write = 1'b1;
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
`ifdef ILLEGAL_TRAP_EN
         StHalt: halted = 1'b1;
`endif
         default: ;
      endcase
   end

   assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner cases and random instruction
// streams checked against a per-instruction step-sequence model.
module tb_mc_controller;
   import lib_cpu::*;

   logic       clk = 1'b0;
   logic       reset_n;
   OPECODE     op;
   FUNCT       funct;
   logic       zero;
   logic       pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic       halted;

   int n_cmp = 0;
   int n_bad = 0;

   mc_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .pc_en(pc_en), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
      .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control), .halted(halted)
   );

   always #5 clk = ~clk;

   // Packed view: {halted, pc_en, ir_w, mem_w, reg_w, iord, m2r, reg_dst, src_a, src_b, pc_src, alu}
   function automatic logic [15:0] outv();
      return {halted, pc_en, ir_write, mem_write, reg_write, iord, mem_to_reg, reg_dst,
              alu_src_a, alu_src_b, pc_src, alu_control};
   endfunction

   function automatic logic [15:0] mk(logic pe, logic irw, logic mw, logic rw, logic io,
                                      logic m2r, logic rd, logic sa, logic [1:0] sb,
                                      logic [1:0] ps, logic [2:0] alu, logic h);
      return {h, pe, irw, mw, rw, io, m2r, rd, sa, sb, ps, alu};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] alu_of(FUNCT f);
      case (f)
         SUB:     return 3'b110;
         AND:     return 3'b000;
         OR:      return 3'b001;
         SLT:     return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   // Step count per instruction, FETCH included; trapped instructions end at the faulting step.
   function automatic int n_steps(OPECODE o, FUNCT f);
      case (o)
         LW:    return 5;
         SW:    return 4;
`ifdef ILLEGAL_TRAP_EN
         RTYPE: return (f == INVALID_FU) ? 3 : 4;
`else
         RTYPE: return (f == INVALID_FU) ? 4 : 4;
`endif
         ADDI:  return 4;
         BEQ:   return 3;
         J:     return 3;
         default: return 2;
      endcase
   endfunction

   function automatic string step_name(OPECODE o, int k);
      if (k == 0) return "FETCH";
      if (k == 1) return "DECODE";
      case (o)
         LW:    return (k == 2) ? "MEMADR" : (k == 3) ? "MEMRD" : "MEMWB";
         SW:    return (k == 2) ? "MEMADR" : "MEMWR";
         RTYPE: return (k == 2) ? "EXEC" : "ALUWB";
         ADDI:  return (k == 2) ? "ADDIEX" : "ADDIWB";
         BEQ:   return "BRANCH";
         J:     return "JUMP";
         default: return "HALT";
      endcase
   endfunction

   function automatic logic [15:0] step_vec(string s, FUNCT f, logic z);
      case (s)
         "FETCH":  return mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
         "DECODE": return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
         "MEMADR": return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
         "MEMRD":  return mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
         "MEMWB":  return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0);
         "MEMWR":  return mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
         "EXEC":   return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu_of(f), 0);
         "ALUWB":  return mk(0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
         "BRANCH": return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0);
         "ADDIEX": return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
         "ADDIWB": return mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
         "JUMP":   return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
         "HALT":   return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic scramble();
      op    = OPECODE'(3'($urandom_range(0, 6)));
      funct = FUNCT'(3'($urandom_range(0, 5)));
      zero  = 1'($urandom);
   endtask

   // Leaves the DUT in RST for the cycle before the next rising edge.
   task automatic do_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("reset_async", outv(), 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      scramble();
      @(negedge clk);
      check("reset_rst_state", outv(), 16'h0000);
   endtask

   // Real op/funct only in the decode/execute steps; noise elsewhere must be ignored.
   task automatic run_instr(input OPECODE o, input FUNCT f, input logic zb, input string name,
                            output logic [15:0] last);
      int n;
      n = n_steps(o, f);
      last = 16'h0000;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1 scramble();
         if (k == 1 || k == 2) begin
            op    = o;
            funct = f;
         end
         if (k == 2) zero = zb;
         @(negedge clk);
         last = outv();
         check($sformatf("%s c%0d %s", name, k, step_name(o, k)), last,
               step_vec(step_name(o, k), f, zero));
      end
   endtask

   task automatic hold_halt(input int cycles, input string name);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1 scramble();
         @(negedge clk);
         check($sformatf("%s halt%0d", name, i), outv(), 16'h8000);
      end
   endtask

   typedef struct {
      OPECODE      o;
      FUNCT        f;
      logic        z;
      logic [15:0] last;
      string       name;
   } vec_t;

   vec_t        tbl[11];
   int          n_tbl;
   logic [15:0] last;

   initial begin
      reset_n = 1'b0;
      op      = LW;
      funct   = ADD;
      zero    = 1'b0;

      tbl[0]  = '{LW,    ADD, 1'b0, 16'h0A00, "lw"};
      tbl[1]  = '{SW,    ADD, 1'b0, 16'h1400, "sw"};
      tbl[2]  = '{RTYPE, ADD, 1'b0, 16'h0900, "add"};
      tbl[3]  = '{RTYPE, SUB, 1'b0, 16'h0900, "sub"};
      tbl[4]  = '{RTYPE, SLT, 1'b1, 16'h0900, "slt"};
      tbl[5]  = '{BEQ,   ADD, 1'b1, 16'h408E, "beq_taken"};
      tbl[6]  = '{BEQ,   ADD, 1'b0, 16'h008E, "beq_not"};
      tbl[7]  = '{ADDI,  OR,  1'b0, 16'h0800, "addi"};
      tbl[8]  = '{J,     AND, 1'b1, 16'h4010, "j"};
      n_tbl   = 9;
`ifndef ILLEGAL_TRAP_EN
      tbl[9]  = '{INVALID_OP, ADD,        1'b0, 16'h0062, "nop"};
      tbl[10] = '{RTYPE,      INVALID_FU, 1'b0, 16'h0900, "bad_funct"};
      n_tbl   = 11;
`endif

      do_reset();
      for (int i = 0; i < n_tbl; i++) begin
         run_instr(tbl[i].o, tbl[i].f, tbl[i].z, tbl[i].name, last);
         check({tbl[i].name, "_last"}, last, tbl[i].last);
      end

      // Reset asserted while the store strobe is active.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 scramble();
         if (k == 1 || k == 2) op = SW;
      end
      #1 check("memwr_strobe", outv(), 16'h1400);
      reset_n = 1'b0;
      #1 check("memwr_reset_same_cycle", outv(), 16'h0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("memwr_reset_rst", outv(), 16'h0000);
      run_instr(BEQ, ADD, 1'b1, "after_reset", last);

`ifdef ILLEGAL_TRAP_EN
      do_reset();
      run_instr(INVALID_OP, ADD, 1'b0, "trap_op", last);
      hold_halt(10, "trap_op");
      do_reset();
      run_instr(RTYPE, INVALID_FU, 1'b0, "trap_fu", last);
      hold_halt(3, "trap_fu");
      do_reset();
`endif

      for (int i = 0; i < 300; i++) begin
         OPECODE o;
         FUNCT   f;
`ifdef ILLEGAL_TRAP_EN
         o = OPECODE'(3'($urandom_range(0, 5)));
         f = FUNCT'(3'($urandom_range(0, 4)));
`else
         o = OPECODE'(3'($urandom_range(0, 6)));
         f = FUNCT'(3'($urandom_range(0, 5)));
`endif
         run_instr(o, f, 1'($urandom), $sformatf("rnd%0d", i), last);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
